// File: rtl/composer_transport_ctrl.sv
// composer_transport_ctrl
//   Transport sequencer for the composer note store, an external single-port
//   RAM of 2**ADDR_W notes. It decodes record/play/stop/erase pulses, derives
//   the note tick from the system clock, drives the RAM address/data/strobe,
//   tracks the recorded length and plays notes back to the tone generator.
//   The end of a sequence is set by the length register, never by a note value.
//
// Ports
//   clk_5MHz   system clock, rising edge
//   reset      asynchronous, active-high
//   cmd_*      1-cycle command pulses (record, play, stop, erase)
//   loop_en    level; playback wraps to note 0 at the end when high
//   key_in     key code written on record ticks
//   mem_addr   RAM address, combinational from state and pointers
//   mem_wdata  RAM write data
//   mem_we     RAM write strobe, single-cycle pulses
//   mem_rdata  RAM read data, valid one cycle after the address
//   note_out   registered playback note, held until the next update
//   note_valid 1-cycle pulse when note_out updates
//   length     number of stored notes, 0..DEPTH
//   full       length == DEPTH
//   state_out  0 IDLE, 1 RECORD, 2 PLAY, 3 ERASE
module composer_transport_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 312500
) (
  input  logic              clk_5MHz,
  input  logic              reset,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              cmd_erase,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] key_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] note_out,
  output logic              note_valid,
  output logic [ADDR_W:0]   length,
  output logic              full,
  output logic [1:0]        state_out
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_ERASE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    length_q, length_d;
  // play_ptr needs the extra bit: without looping it reaches length (up to DEPTH)
  logic [ADDR_W:0]    play_ptr_q, play_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]  note_out_q, note_out_d;
  logic               note_valid_q, note_valid_d;

  logic               tick;
  logic               full_w;
  logic [ADDR_W:0]    last_idx;

  assign tick     = (cnt_q == TICK_LAST);
  assign full_w   = (length_q == DEPTH_L);
  assign last_idx = length_q - LEN_ONE;

  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      length_q     <= '0;
      play_ptr_q   <= '0;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      note_out_q   <= '0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      play_ptr_q   <= play_ptr_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      note_out_q   <= note_out_d;
      note_valid_q <= note_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    play_ptr_d   = play_ptr_q;
    cnt_d        = tick ? '0 : cnt_q + CNT_ONE;
    rd_pend_d    = 1'b0;
    note_out_d   = note_out_q;
    note_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    mem_addr     = length_q[ADDR_W-1:0];

    // A read issued on the previous tick returns now; a stop below discards it.
    if (state_q == S_PLAY && rd_pend_q) begin
      note_out_d   = mem_rdata;
      note_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Stop masks the lower-priority pulses even though it is a no-op here.
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (cmd_record) begin
          if (!full_w) begin
            state_d = S_RECORD;
            cnt_d   = '0;
          end
        end else if (cmd_play) begin
          if (length_q != '0) begin
            state_d    = S_PLAY;
            play_ptr_d = '0;
            cnt_d      = '0;
          end
        end else if (cmd_erase) begin
          state_d = S_ERASE;
        end
      end

      S_RECORD: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          mem_we    = 1'b1;
          mem_wdata = key_in;
          length_d  = length_q + LEN_ONE;
          if (length_q == DEPTH_L - LEN_ONE) begin
            state_d = S_IDLE;
          end
        end
      end

      S_ERASE: begin
        mem_addr = last_idx[ADDR_W-1:0];
        if (length_q != '0) begin
          mem_we   = 1'b1;
          length_d = last_idx;
        end
        state_d = S_IDLE;
      end

      S_PLAY: begin
        mem_addr = play_ptr_q[ADDR_W-1:0];
        if (cmd_stop) begin
          state_d      = S_IDLE;
          note_out_d   = '0;
          note_valid_d = 1'b0;
        end else if (tick) begin
          if (play_ptr_q < length_q) begin
            rd_pend_d  = 1'b1;
            play_ptr_d = (loop_en && play_ptr_q == last_idx) ? '0 : play_ptr_q + LEN_ONE;
          end else begin
            state_d    = S_IDLE;
            note_out_d = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign length     = length_q;
  assign full       = full_w;
  assign state_out  = state_q;

endmodule

// File: tb/tb_composer_transport_ctrl.sv
module tb_composer_transport_ctrl;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int TDIV   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_record = 1'b0, cmd_play = 1'b0, cmd_stop = 1'b0, cmd_erase = 1'b0;
  logic              loop_en = 1'b0;
  logic [DATA_W-1:0] key_in = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] note_out;
  logic              note_valid;
  logic [ADDR_W:0]   length;
  logic              full;
  logic [1:0]        state_out;

  composer_transport_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TDIV)) dut (
    .clk_5MHz(clk), .reset(reset),
    .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_stop(cmd_stop), .cmd_erase(cmd_erase),
    .loop_en(loop_en), .key_in(key_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .note_out(note_out), .note_valid(note_valid),
    .length(length), .full(full), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one-cycle read latency.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rdata_q <= ram[mem_addr];
  end
  assign mem_rdata = rdata_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int exp_len = 0;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int cyc; } wr_t;
  typedef struct { logic [DATA_W-1:0] data; int cyc; } note_t;
  wr_t   wr_q[$];
  note_t note_q[$];

  // Scoreboard: every write strobe and every note pulse must match the head entry.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected got addr=%0h data=%0h cyc=%0d, required none", mem_addr, mem_wdata, cyc);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL write got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (note_valid === 1'b1) begin
      vectors++;
      if (note_q.size() == 0) begin
        miscompares++;
        $display("FAIL note_unexpected got note=%0h cyc=%0d, required none", note_out, cyc);
      end else begin
        note_t n;
        n = note_q.pop_front();
        if (note_out !== n.data || cyc !== n.cyc) begin
          miscompares++;
          $display("FAIL note got note=%0h cyc=%0d, required note=%0h cyc=%0d", note_out, cyc, n.data, n.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic check_status(input string name, input logic [1:0] st, input int len, input logic [DATA_W-1:0] nout);
    vectors++;
    if (state_out !== st || length !== (ADDR_W+1)'(len) || note_out !== nout) begin
      miscompares++;
      $display("FAIL %s got state=%0d length=%0d note=%0h, required state=%0d length=%0d note=%0h",
               name, state_out, length, note_out, st, len, nout);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (wr_q.size() != 0 || note_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s got pending writes=%0d notes=%0d, required 0 and 0", name, wr_q.size(), note_q.size());
    end
  endtask

  // Record n notes with key (i+1)*mul; first tick lands TDIV cycles after the command cycle.
  task automatic do_record(input int n, input int mul, input bit stop_after);
    int k;
    k = cyc;
    for (int i = 0; i < n; i++)
      wr_q.push_back('{addr: ADDR_W'(exp_len + i), data: DATA_W'((i + 1) * mul), cyc: k + TDIV * (i + 1)});
    cmd_record = 1'b1;
    key_in = DATA_W'(mul);
    step();
    cmd_record = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_until(k + TDIV * i + 1);
      key_in = DATA_W'((i + 1) * mul);
    end
    wait_until(k + TDIV * n + 1);
    if (stop_after) begin
      cmd_stop = 1'b1;
      step();
      cmd_stop = 1'b0;
    end
    exp_len += n;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (state_out !== 2'd0 || length !== '0 || note_out !== '0 || note_valid !== 1'b0 ||
        mem_we !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got state=%0d length=%0d note=%0h valid=%0b we=%0b full=%0b, required all 0",
               state_out, length, note_out, note_valid, mem_we, full);
    end
    reset = 1'b0;
    step();
    check_status("reset_release", 2'd0, 0, 8'h00);
    exp_len = 0;
  endtask

  task automatic test_record();
    do_record(3, 'h11, 1'b1);
    step();
    check_status("record_stop", 2'd0, 3, 8'h00);
    check_drained("record_drain");
  endtask

  task automatic test_play();
    int k;
    k = cyc;
    note_q.push_back('{data: 8'h11, cyc: k + 6});
    note_q.push_back('{data: 8'h22, cyc: k + 10});
    note_q.push_back('{data: 8'h33, cyc: k + 14});
    cmd_play = 1'b1;
    step();
    cmd_play = 1'b0;
    check_status("play_enter", 2'd2, 3, 8'h00);
    wait_until(k + 16);
    check_status("play_hold_last", 2'd2, 3, 8'h33);
    wait_until(k + 17);
    check_status("play_end", 2'd0, 3, 8'h00);
    wait_until(k + 22);
    check_drained("play_drain");
  endtask

  task automatic test_erase();
    int k;
    k = cyc;
    wr_q.push_back('{addr: 7'd2, data: 8'h00, cyc: k + 1});
    cmd_erase = 1'b1;
    step();
    cmd_erase = 1'b0;
    check_status("erase_state", 2'd3, 3, 8'h00);
    step();
    exp_len = 2;
    check_status("erase_done", 2'd0, 2, 8'h00);
    check_drained("erase_drain");
  endtask

  task automatic test_loop();
    int k;
    loop_en = 1'b1;
    k = cyc;
    note_q.push_back('{data: 8'h11, cyc: k + 6});
    note_q.push_back('{data: 8'h22, cyc: k + 10});
    note_q.push_back('{data: 8'h11, cyc: k + 14});
    note_q.push_back('{data: 8'h22, cyc: k + 18});
    cmd_play = 1'b1;
    step();
    cmd_play = 1'b0;
    wait_until(k + 20);
    // Stop lands on the tick cycle: the tick's read must not produce a note.
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    check_status("loop_stop", 2'd0, 2, 8'h00);
    wait_until(k + 26);
    check_drained("loop_drain");
    loop_en = 1'b0;
  endtask

  task automatic test_erase_empty();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_len = 0;
    step();
    cmd_erase = 1'b1;
    step();
    cmd_erase = 1'b0;
    check_status("erase_empty_state", 2'd3, 0, 8'h00);
    step();
    check_status("erase_empty_done", 2'd0, 0, 8'h00);
    step();
    check_drained("erase_empty_drain");
  endtask

  task automatic test_full();
    do_record(128, 3, 1'b0);
    check_status("full_auto_idle", 2'd0, 128, 8'h00);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_flag got %0b, required 1", full);
    end
    cmd_record = 1'b1;
    step();
    cmd_record = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check_status("full_record_ignored", 2'd0, 128, 8'h00);
    check_drained("full_drain");
  endtask

  task automatic test_reset_mid();
    int k;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_len = 0;
    step();
    // Reset after one record write: everything returns to IDLE at once.
    k = cyc;
    wr_q.push_back('{addr: 7'd0, data: 8'h44, cyc: k + 4});
    key_in = 8'h44;
    cmd_record = 1'b1;
    step();
    cmd_record = 1'b0;
    wait_until(k + 6);
    reset = 1'b1;
    #1;
    vectors++;
    if (state_out !== 2'd0 || length !== '0 || mem_we !== 1'b0 || note_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_record got state=%0d length=%0d we=%0b, required 0 0 0", state_out, length, mem_we);
    end
    reset = 1'b0;
    exp_len = 0;
    step();
    do_record(2, 'h11, 1'b1);
    step();
    // Reset while a playback read is in flight: no note may follow.
    k = cyc;
    note_q.push_back('{data: 8'h11, cyc: k + 6});
    cmd_play = 1'b1;
    step();
    cmd_play = 1'b0;
    wait_until(k + 7);
    check_status("reset_mid_play_pre", 2'd2, 2, 8'h11);
    wait_until(k + 9);
    reset = 1'b1;
    #1;
    vectors++;
    if (state_out !== 2'd0 || length !== '0 || note_out !== '0 || note_valid !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_play got state=%0d length=%0d note=%0h valid=%0b, required 0 0 0 0",
               state_out, length, note_out, note_valid);
    end
    reset = 1'b0;
    exp_len = 0;
    for (int i = 0; i < 8; i++) step();
    check_status("reset_mid_after", 2'd0, 0, 8'h00);
    check_drained("reset_mid_drain");
  endtask

  initial begin
    test_reset();
    test_record();
    test_play();
    test_erase();
    test_loop();
    test_erase_empty();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
